cfg_frame_loader: RTL and testbench
===================================

Name: cfg_frame_loader

Overview:
- Configuration loader for the fabric's config storage. Accepts a word-serial bitstream over a valid/ready handshake and decodes a header word into a tile select.
- Demultiplexes the following data words to that tile's config register file with a one-hot write strobe.
- Performs the inverse of the select-mux path: one stream in, N tile destinations out. It sits between the chip config port and the per-tile config registers that drive the routing-mux selects.

Parameters:
- WIDTH, 8, config word width in bits; must be >= AW+1.
- NUM_TILES, 4, number of destination tiles; must be >= 1.
- WORDS_PER_TILE, 4, data words per frame; must be >= 1.
- Derived localparams (not overridable):
  - AW = max(1, clog2(NUM_TILES)).
  - CW = max(1, clog2(WORDS_PER_TILE)).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  stream word valid.
- in_data  input  WIDTH  stream word.
- in_ready  output  1  block can accept a word this cycle.
- cfg_we  output  NUM_TILES  one-hot write strobe, bit i targets tile i.
- cfg_addr  output  CW  word index within the tile.
- cfg_data  output  WIDTH  word to write.
- done  output  1  one-cycle pulse after a frame completes.
- err  output  1  one-cycle pulse when a header is rejected.

Behaviour:
- Clock and reset:
  - One clock (clk). Reset rst is asynchronous and active-high.
  - All state and outputs are registered. A word is accepted when in_valid && in_ready are both sampled high at a clk rising edge.
- Reset values:
  - state = HDR, word counter = 0, tile register = 0.
  - cfg_we = 0, cfg_addr = 0, cfg_data = 0, done = 0, err = 0.
  - in_ready = 1 from the first cycle after reset deasserts.
- Header word format:
  - in_data[WIDTH-1] = sync marker; must be 1.
  - in_data[AW-1:0] = tile index; must be < NUM_TILES.
  - All other bits are ignored.
- FSM states: HDR, DATA, DONE.
  - HDR: in_ready=1.
    - Accepted header that passes both checks: latch the tile index, clear the counter, go to DATA.
    - Failed check: err=1 in the following cycle, stay in HDR. The word is discarded.
  - DATA: in_ready=1. On each accept:
    - Next cycle: cfg_we has only bit[tile] set; cfg_addr = counter; cfg_data = in_data.
    - Counter then increments.
    - When counter == WORDS_PER_TILE-1 at the accept, go to DONE.
  - DONE: lasts exactly one cycle.
    - done=1 and in_ready=0 (in_ready is combinational from state).
    - Next state is HDR.
- Output timing:
  - cfg_we is high only in the cycle after a data accept; it is 0 on every other cycle.
  - cfg_addr and cfg_data hold their last values when cfg_we=0.
  - Latency is one cycle from data accept to write strobe. Gap-free streaming gives one write per cycle.
  - The last write strobe and done are in the same cycle.
- Stalls: in_valid low in DATA does not change state or counter; no strobe is produced. Any number of idle cycles is allowed.
- Data word contents are not checked. The marker bit in a data word is ignored.
- Reset mid-frame: returns to HDR immediately (asynchronous). The partial frame is abandoned and nothing is retried. Tile registers already written keep their contents.
- in_data while in_valid=0 has no effect.
- NUM_TILES == 2^AW: the out-of-range check can never fire; only the marker check applies.

Decomposition:
- Shared package cfg_pkg holds:
  - FSM state encoding constants (ST_HDR=2'd0, ST_DATA=2'd1, ST_DONE=2'd2).
  - Header field positions (SYNC_BIT = WIDTH-1, tile field LSB = 0).
  - A clog2 helper function.
- One sub-module is natural: cfg_onehot_dec (AW-bit index in, NUM_TILES-bit one-hot out, gated by an enable). It is the demux counterpart of the existing mux primitive. The FSM, counter and output registers stay in cfg_frame_loader.

Test Plan:
- Reset: assert rst mid-idle → all outputs 0 and in_ready=0 while rst is high. Deassert → in_ready=1, state HDR.
- Header 0x82 then data 0x11,0x22,0x33,0x44 back-to-back:
  - cfg_we=4'b0100 on 4 consecutive cycles, with addr 0..3 and data 0x11..0x44.
  - done=1 in the same cycle as the last strobe.
  - in_ready=0 for exactly 1 cycle, then a new header is accepted.
- Header 0x03 (marker 0) → err pulse 1 cycle, no cfg_we, still HDR. A following header 0x81 is accepted normally and targets tile 1.
- NUM_TILES=3, header 0x83 → err pulse, no strobes. Header 0x82 then 4 words → writes go to tile 2.
- Stalls: header 0x80, then data with in_valid toggling 1,0,0,1,0,1,1 → strobes appear only in the cycles after accepts, with addr 0,1,2,3 in order and no duplicates.
- Header 0x81, 2 data words, then assert rst → no further strobes and no done. After release, a full frame to tile 3 completes with addr starting at 0.

Source files
------------

// File: rtl/cfg_pkg.sv
// Shared definitions for the configuration frame loader: FSM encoding,
// header field positions and elaboration-time sizing helpers.
package cfg_pkg;

  typedef enum logic [1:0] {
    ST_HDR  = 2'd0,
    ST_DATA = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Tile index occupies the low bits of the header word.
  localparam int TILE_LSB = 0;

  // Sync marker sits in the top bit of the header word.
  function automatic int sync_bit(input int width);
    return width - 1;
  endfunction

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Field widths never collapse to zero bits.
  function automatic int max1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

endpackage

// File: rtl/cfg_onehot_dec.sv
// Index-to-one-hot decoder gated by an enable; the demux counterpart of the
// routing select mux.
module cfg_onehot_dec #(
  parameter int AW = 2,
  parameter int N  = 4
) (
  input  logic          en_i,
  input  logic [AW-1:0] idx_i,
  output logic [N-1:0]  onehot_o
);

  // Raise exactly the bit selected by idx_i when enabled, nothing otherwise.
  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < N; i++) begin
      if (en_i && (idx_i == AW'(i))) onehot_o[i] = 1'b1;
    end
  end

endmodule

// File: rtl/cfg_frame_loader.sv
// Word-serial configuration loader: a header word selects a tile, the
// following WORDS_PER_TILE words are written into that tile's config
// register file through a one-hot strobe.
module cfg_frame_loader
  import cfg_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int NUM_TILES      = 4,
  parameter int WORDS_PER_TILE = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  input  logic [WIDTH-1:0]                      in_data,
  output logic                                  in_ready,
  output logic [NUM_TILES-1:0]                  cfg_we,
  output logic [max1(clog2(WORDS_PER_TILE))-1:0] cfg_addr,
  output logic [WIDTH-1:0]                      cfg_data,
  output logic                                  done,
  output logic                                  err
);

  localparam int AW   = max1(clog2(NUM_TILES));
  localparam int CW   = max1(clog2(WORDS_PER_TILE));
  localparam int SYNC = sync_bit(WIDTH);

  localparam logic [AW:0]   NT_LIM = (AW+1)'(NUM_TILES);
  localparam logic [CW-1:0] LAST   = CW'(WORDS_PER_TILE - 1);

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [AW-1:0]        tile_q, tile_d;
  logic [NUM_TILES-1:0] we_q, we_d;
  logic [CW-1:0]        addr_q, addr_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  // Holds in_ready low while reset is applied and releases it on the
  // first clock edge after reset deasserts.
  logic                 rdy_q;

  logic                 accept;
  logic                 hdr_ok;
  logic                 strobe_en;
  logic [AW-1:0]        hdr_tile;
  logic [NUM_TILES-1:0] dec_we;

  assign in_ready  = rdy_q && (state_q != ST_DONE);
  assign accept    = in_valid && in_ready;
  assign hdr_tile  = in_data[TILE_LSB +: AW];
  assign hdr_ok    = in_data[SYNC] && ({1'b0, hdr_tile} < NT_LIM);
  assign strobe_en = accept && (state_q == ST_DATA);

  cfg_onehot_dec #(
    .AW (AW),
    .N  (NUM_TILES)
  ) u_dec (
    .en_i     (strobe_en),
    .idx_i    (tile_q),
    .onehot_o (dec_we)
  );

  // Next-state and registered-output logic for the header/data/done sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tile_d  = tile_q;
    we_d    = '0;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_HDR: begin
        if (accept) begin
          if (hdr_ok) begin
            tile_d  = hdr_tile;
            cnt_d   = '0;
            state_d = ST_DATA;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (accept) begin
          we_d   = dec_we;
          addr_d = cnt_q;
          data_d = in_data;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_HDR;
      end
      default: begin
        state_d = ST_HDR;
      end
    endcase
  end

  // State, counter and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_HDR;
      cnt_q   <= '0;
      tile_q  <= '0;
      we_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tile_q  <= tile_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdy_q   <= 1'b1;
    end
  end

  assign cfg_we   = we_q;
  assign cfg_addr = addr_q;
  assign cfg_data = data_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_cfg_frame_loader.sv
// Bench for cfg_frame_loader: two instances (4 tiles and 3 tiles) share one
// stimulus stream and are each compared every cycle against a frame-level model.
module tb_cfg_frame_loader;

  localparam int W   = 8;
  localparam int WPT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;

  logic       rdy4, rdy3, done4, done3, err4, err3;
  logic [3:0] we4;
  logic [2:0] we3;
  logic [1:0] addr4, addr3;
  logic [7:0] data4, data3;

  always #5 clk = ~clk;

  cfg_frame_loader #(.WIDTH(W), .NUM_TILES(4), .WORDS_PER_TILE(WPT)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy4), .cfg_we(we4), .cfg_addr(addr4), .cfg_data(data4),
    .done(done4), .err(err4));

  cfg_frame_loader #(.WIDTH(W), .NUM_TILES(3), .WORDS_PER_TILE(WPT)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy3), .cfg_we(we3), .cfg_addr(addr3), .cfg_data(data3),
    .done(done3), .err(err3));

  int total = 0;
  int bad   = 0;

  // Model: per instance, whether ready is live, whether inside a frame,
  // whether in the post-frame gap cycle, selected tile and words written.
  int         ntiles[2] = '{4, 3};
  bit         m_live[2], m_frame[2], m_gap[2];
  int         m_tile[2], m_idx[2];
  logic [3:0] e_we[2];
  logic [1:0] e_addr[2];
  logic [7:0] e_data[2];
  logic       e_done[2], e_err[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_live[k] = 0; m_frame[k] = 0; m_gap[k] = 0;
      m_tile[k] = 0; m_idx[k] = 0;
      e_we[k] = '0; e_addr[k] = '0; e_data[k] = '0;
      e_done[k] = 0; e_err[k] = 0;
    end
  endtask

  // One clock edge of the frame-level behaviour for instance k.
  task automatic model_step(input int k);
    bit acc;
    int tfield;
    acc = in_valid && m_live[k] && !m_gap[k];
    e_we[k] = '0; e_done[k] = 0; e_err[k] = 0;
    if (!m_live[k]) begin
      m_live[k] = 1;
    end else if (m_gap[k]) begin
      m_gap[k] = 0;
    end else if (acc) begin
      if (!m_frame[k]) begin
        tfield = int'(in_data) % 4;
        if (in_data[7] && tfield < ntiles[k]) begin
          m_frame[k] = 1; m_tile[k] = tfield; m_idx[k] = 0;
        end else begin
          e_err[k] = 1;
        end
      end else begin
        e_we[k]   = 4'(1 << m_tile[k]);
        e_addr[k] = 2'(m_idx[k]);
        e_data[k] = in_data;
        m_idx[k]++;
        if (m_idx[k] == WPT) begin
          m_frame[k] = 0; m_gap[k] = 1; e_done[k] = 1;
        end
      end
    end
  endtask

  task automatic check_all();
    logic e_rdy;
    for (int k = 0; k < 2; k++) begin
      e_rdy = m_live[k] && !m_gap[k];
      if (k == 0) begin
        chk("t4_ready", rdy4, e_rdy);
        chk("t4_we", we4, e_we[0]);
        chk("t4_addr", addr4, e_addr[0]);
        chk("t4_data", data4, e_data[0]);
        chk("t4_done", done4, e_done[0]);
        chk("t4_err", err4, e_err[0]);
      end else begin
        chk("t3_ready", rdy3, e_rdy);
        chk("t3_we", {1'b0, we3}, e_we[1]);
        chk("t3_addr", addr3, e_addr[1]);
        chk("t3_data", data3, e_data[1]);
        chk("t3_done", done3, e_done[1]);
        chk("t3_err", err3, e_err[1]);
      end
    end
  endtask

  // Present one input word across a rising edge, then compare at the falling edge.
  task automatic cycle(input logic v, input logic [7:0] d);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    if (!rst) begin
      model_step(0);
      model_step(1);
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    model_reset();
    #1;
    check_all();
    repeat (n) cycle(1'b0, 8'h00);
    rst = 1'b0;
    cycle(1'b0, 8'h00);
  endtask

  initial begin
    #1;
    do_reset(2);
    chk("lit_ready_after_rst", rdy4, 1'b1);

    // Frame to tile 2, back-to-back data.
    cycle(1'b1, 8'h82);
    cycle(1'b1, 8'h11);
    chk("lit_we0", we4, 4'b0100);
    chk("lit_addr0", addr4, 2'd0);
    chk("lit_data0", data4, 8'h11);
    cycle(1'b1, 8'h22);
    chk("lit_addr1", addr4, 2'd1);
    cycle(1'b1, 8'h33);
    chk("lit_we2", we4, 4'b0100);
    cycle(1'b1, 8'h44);
    chk("lit_we3", we4, 4'b0100);
    chk("lit_addr3", addr4, 2'd3);
    chk("lit_data3", data4, 8'h44);
    chk("lit_done", done4, 1'b1);
    chk("lit_ready_gap", rdy4, 1'b0);
    chk("lit_t3_we3", {1'b0, we3}, 4'b0100);
    cycle(1'b0, 8'h00);
    chk("lit_ready_back", rdy4, 1'b1);
    chk("lit_we_idle", we4, 4'b0000);

    // Missing marker rejected, then a good header to tile 1.
    cycle(1'b1, 8'h03);
    chk("lit_err", err4, 1'b1);
    chk("lit_err_no_we", we4, 4'b0000);
    cycle(1'b1, 8'h81);
    chk("lit_err_pulse", err4, 1'b0);
    cycle(1'b1, 8'h5a);
    chk("lit_we_t1", we4, 4'b0010);
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h60 + i));
    cycle(1'b0, 8'h00);

    // Out-of-range tile on the 3-tile instance; valid on the 4-tile one.
    cycle(1'b1, 8'h83);
    chk("lit_t3_err", err3, 1'b1);
    chk("lit_t4_no_err", err4, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h70 + i));
    cycle(1'b0, 8'h00);
    cycle(1'b0, 8'h00);
    cycle(1'b1, 8'h82);
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'hA0 + i));
    cycle(1'b0, 8'h00);

    // Stalled data stream to tile 0.
    cycle(1'b1, 8'h80);
    begin
      logic [6:0] pat;
      pat = 7'b1001011;
      for (int i = 0; i < 7; i++) cycle(pat[6-i], 8'(8'h20 + i));
    end
    cycle(1'b0, 8'h00);
    cycle(1'b0, 8'h00);

    // Reset in the middle of a frame, then a full frame to tile 3.
    cycle(1'b1, 8'h81);
    cycle(1'b1, 8'hB0);
    cycle(1'b1, 8'hB1);
    do_reset(1);
    cycle(1'b1, 8'h83);
    cycle(1'b1, 8'hC0);
    chk("lit_post_rst_addr", addr4, 2'd0);
    chk("lit_post_rst_we", we4, 4'b1000);
    for (int i = 1; i < 4; i++) cycle(1'b1, 8'(8'hC0 + i));
    cycle(1'b0, 8'h00);

    // Randomised traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      logic [7:0] d;
      d = 8'($urandom);
      if ($urandom_range(0, 2) == 0) d[7] = 1'b1;
      if ($urandom_range(0, 199) == 0) do_reset(int'($urandom_range(1, 2)));
      else cycle($urandom_range(0, 9) < 7, d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
